// File: rtl/multicycle_sequencer.sv
// Multi-cycle MIPS control sequencer: one shared ALU and memory port,
// stepping each instruction through FETCH/DECODE/EXEC/MEM/WB.
package multicycle_sequencer_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_FAULT  = 3'd7
  } state_e;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_NOR = 3'd4;
  localparam logic [2:0] OP_SLT = 3'd5;
  localparam logic [2:0] OP_SLL = 3'd6;
  localparam logic [2:0] OP_SRL = 3'd7;

  localparam logic [1:0] ALU_SRC_REG_B      = 2'd0;
  localparam logic [1:0] ALU_SRC_SEXT_IMM16 = 2'd1;
  localparam logic [1:0] ALU_SRC_ZEXT_IMM16 = 2'd2;

endpackage

module multicycle_sequencer
  import multicycle_sequencer_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      mem_rdata,
  input  logic             mem_ready,
  input  logic             zero,
  output logic             mem_req,
  output logic             mem_we,
  output logic             addr_sel,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic [1:0]       alu_src,
  output logic [2:0]       alu_op,
  output logic [31:0]      ir,
  output logic [2:0]       state,
  output logic             fault,
  output logic [CNT_W-1:0] retired
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST =
    WAIT_W'(MEM_TIMEOUT - 1);

  state_e             state_q, state_d;
  logic [31:0]        ir_q, ir_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [CNT_W-1:0]   retired_q, retired_d;
  logic               fault_q, fault_d;

  logic [5:0] opc;
  logic [5:0] fn;
  logic is_r, r_ok, is_addi, is_andi, is_ori;
  logic is_lw, is_sw, is_beq, is_bne, is_j;
  logic legal;
  logic [2:0] alu_op_x;
  logic [1:0] alu_src_x;

  assign opc     = ir_q[31:26];
  assign fn      = ir_q[5:0];
  assign is_r    = (opc == 6'h00);
  assign is_addi = (opc == 6'h08);
  assign is_andi = (opc == 6'h0C);
  assign is_ori  = (opc == 6'h0D);
  assign is_lw   = (opc == 6'h23);
  assign is_sw   = (opc == 6'h2B);
  assign is_beq  = (opc == 6'h04);
  assign is_bne  = (opc == 6'h05);
  assign is_j    = (opc == 6'h02);

  assign r_ok = is_r && (fn inside {
    6'h20, 6'h22, 6'h24, 6'h25,
    6'h27, 6'h2A, 6'h00, 6'h02});

  assign legal = r_ok | is_addi | is_andi | is_ori |
                 is_lw | is_sw | is_beq | is_bne | is_j;

  assign ir      = ir_q;
  assign state   = state_q;
  assign fault   = fault_q;
  assign retired = retired_q;

  // ALU operation and operand select implied by the held instruction
  always_comb begin
    alu_op_x  = OP_ADD;
    alu_src_x = ALU_SRC_REG_B;
    unique case (1'b1)
      is_r: begin
        case (fn)
          6'h22:   alu_op_x = OP_SUB;
          6'h24:   alu_op_x = OP_AND;
          6'h25:   alu_op_x = OP_OR;
          6'h27:   alu_op_x = OP_NOR;
          6'h2A:   alu_op_x = OP_SLT;
          6'h00:   alu_op_x = OP_SLL;
          6'h02:   alu_op_x = OP_SRL;
          default: alu_op_x = OP_ADD;
        endcase
      end
      is_addi, is_lw, is_sw: begin
        alu_src_x = ALU_SRC_SEXT_IMM16;
      end
      is_andi: begin
        alu_op_x  = OP_AND;
        alu_src_x = ALU_SRC_ZEXT_IMM16;
      end
      is_ori: begin
        alu_op_x  = OP_OR;
        alu_src_x = ALU_SRC_ZEXT_IMM16;
      end
      is_beq, is_bne: begin
        alu_op_x = OP_SUB;
      end
      default: ;
    endcase
  end

  // Next state, register updates and per-state control strobes
  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    wait_d     = wait_q;
    retired_d  = retired_q;
    fault_d    = fault_q;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    addr_sel   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 2'd0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src    = ALU_SRC_REG_B;
    alu_op     = OP_ADD;
    unique case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_d     = mem_rdata;
          pc_write = 1'b1;
          wait_d   = '0;
          state_d  = S_DECODE;
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_FAULT;
          fault_d = 1'b1;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_DECODE: begin
        if (legal) begin
          state_d = S_EXEC;
        end else begin
          state_d = S_FAULT;
          fault_d = 1'b1;
        end
      end
      S_EXEC: begin
        alu_op  = alu_op_x;
        alu_src = alu_src_x;
        if (is_beq || is_bne || is_j) begin
          pc_write  = is_j | (is_beq & zero) |
                      (is_bne & ~zero);
          pc_src    = is_j ? 2'd2 : 2'd1;
          wait_d    = '0;
          retired_d = retired_q + CNT_W'(1);
          state_d   = S_FETCH;
        end else if (is_lw || is_sw) begin
          wait_d  = '0;
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = is_sw;
        if (mem_ready) begin
          wait_d = '0;
          if (is_sw) begin
            retired_d = retired_q + CNT_W'(1);
            state_d   = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_FAULT;
          fault_d = 1'b1;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        reg_dst    = is_r;
        mem_to_reg = is_lw;
        wait_d     = '0;
        retired_d  = retired_q + CNT_W'(1);
        state_d    = S_FETCH;
      end
      S_FAULT: ;
      default: begin
        state_d = S_FAULT;
        fault_d = 1'b1;
      end
    endcase
  end

  // State and datapath-control registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      ir_q      <= '0;
      wait_q    <= '0;
      retired_q <= '0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
      fault_q   <= fault_d;
    end
  end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Randomized bench for multicycle_sequencer against an instruction-route
// model, plus directed scenarios with literal expectations.
module tb_multicycle_sequencer;
  import multicycle_sequencer_pkg::*;

  localparam int TO = 16;
  localparam int CW = 16;

  localparam int C_ILL = 0, C_R = 1, C_ADDI = 2, C_ANDI = 3;
  localparam int C_ORI = 4, C_LW = 5, C_SW = 6, C_BEQ = 7;
  localparam int C_BNE = 8, C_J = 9;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [31:0]   mem_rdata = '0;
  logic          mem_ready = 1'b0;
  logic          zero = 1'b0;
  logic          mem_req, mem_we, addr_sel, pc_write;
  logic [1:0]    pc_src;
  logic          reg_write, reg_dst, mem_to_reg;
  logic [1:0]    alu_src;
  logic [2:0]    alu_op;
  logic [31:0]   ir;
  logic [2:0]    state;
  logic          fault;
  logic [CW-1:0] retired;

  multicycle_sequencer #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .zero(zero), .mem_req(mem_req),
    .mem_we(mem_we), .addr_sel(addr_sel), .pc_write(pc_write),
    .pc_src(pc_src), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .alu_src(alu_src), .alu_op(alu_op),
    .ir(ir), .state(state), .fault(fault), .retired(retired)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int            m_route[5];
  int            m_len, m_pos, m_wait;
  bit            m_fault;
  logic [31:0]   m_ir;
  logic [CW-1:0] m_retired;

  function automatic int cls(input logic [31:0] i);
    case (i[31:26])
      6'h00: cls = (i[5:0] inside {6'h20, 6'h22, 6'h24, 6'h25,
                    6'h27, 6'h2A, 6'h00, 6'h02}) ? C_R : C_ILL;
      6'h08: cls = C_ADDI;
      6'h0C: cls = C_ANDI;
      6'h0D: cls = C_ORI;
      6'h23: cls = C_LW;
      6'h2B: cls = C_SW;
      6'h04: cls = C_BEQ;
      6'h05: cls = C_BNE;
      6'h02: cls = C_J;
      default: cls = C_ILL;
    endcase
  endfunction

  function automatic logic [4:0] exp_alu(input logic [31:0] i);
    case (cls(i))
      C_R: begin
        case (i[5:0])
          6'h22: exp_alu = {OP_SUB, ALU_SRC_REG_B};
          6'h24: exp_alu = {OP_AND, ALU_SRC_REG_B};
          6'h25: exp_alu = {OP_OR,  ALU_SRC_REG_B};
          6'h27: exp_alu = {OP_NOR, ALU_SRC_REG_B};
          6'h2A: exp_alu = {OP_SLT, ALU_SRC_REG_B};
          6'h00: exp_alu = {OP_SLL, ALU_SRC_REG_B};
          6'h02: exp_alu = {OP_SRL, ALU_SRC_REG_B};
          default: exp_alu = {OP_ADD, ALU_SRC_REG_B};
        endcase
      end
      C_ADDI, C_LW, C_SW: exp_alu = {OP_ADD, ALU_SRC_SEXT_IMM16};
      C_ANDI: exp_alu = {OP_AND, ALU_SRC_ZEXT_IMM16};
      C_ORI:  exp_alu = {OP_OR,  ALU_SRC_ZEXT_IMM16};
      C_BEQ, C_BNE: exp_alu = {OP_SUB, ALU_SRC_REG_B};
      default: exp_alu = 5'd0;
    endcase
  endfunction

  // Route of phases an instruction visits, fetch included.
  function automatic void set_route(input int c);
    case (c)
      C_ILL: begin m_route = '{0, 1, 0, 0, 0}; m_len = 2; end
      C_BEQ, C_BNE, C_J: begin
        m_route = '{0, 1, 2, 0, 0}; m_len = 3;
      end
      C_LW: begin m_route = '{0, 1, 2, 3, 4}; m_len = 5; end
      C_SW: begin m_route = '{0, 1, 2, 3, 0}; m_len = 4; end
      default: begin m_route = '{0, 1, 2, 4, 0}; m_len = 4; end
    endcase
  endfunction

  function automatic void m_reset();
    m_route   = '{0, 0, 0, 0, 0};
    m_len     = 1;
    m_pos     = 0;
    m_wait    = 0;
    m_fault   = 1'b0;
    m_ir      = '0;
    m_retired = '0;
  endfunction

  function automatic int phase();
    phase = m_fault ? 7 : m_route[m_pos];
  endfunction

  function automatic void advance();
    m_pos++;
    m_wait = 0;
    if (m_pos == m_len) begin
      if (cls(m_ir) == C_ILL) begin
        m_fault = 1'b1;
      end else begin
        m_retired++;
        m_route[0] = 0;
        m_len = 1;
        m_pos = 0;
      end
    end
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_reset();
    end else if (!m_fault) begin
      if (phase() == 0 || phase() == 3) begin
        if (mem_ready) begin
          if (phase() == 0) begin
            m_ir = mem_rdata;
            set_route(cls(mem_rdata));
          end
          advance();
        end else begin
          m_wait++;
          if (m_wait == TO) m_fault = 1'b1;
        end
      end else begin
        advance();
      end
    end
  end

  task automatic model_check();
    int p, c;
    logic [4:0] a;
    logic e_pcw;
    logic [1:0] e_src;
    p = phase();
    c = cls(m_ir);
    a = (p == 2) ? exp_alu(m_ir) : 5'd0;
    e_pcw = (p == 0 && mem_ready) ||
            (p == 2 && ((c == C_BEQ && zero) ||
                        (c == C_BNE && !zero) || c == C_J));
    e_src = 2'd0;
    if (p == 2 && (c == C_BEQ || c == C_BNE)) e_src = 2'd1;
    if (p == 2 && c == C_J) e_src = 2'd2;
    chk("state", state, p);
    chk("mem_req", mem_req, p == 0 || p == 3);
    chk("addr_sel", addr_sel, p == 3);
    chk("mem_we", mem_we, p == 3 && c == C_SW);
    chk("pc_write", pc_write, e_pcw);
    chk("pc_src", pc_src, e_src);
    chk("reg_write", reg_write, p == 4);
    chk("reg_dst", reg_dst, p == 4 && c == C_R);
    chk("mem_to_reg", mem_to_reg, p == 4 && c == C_LW);
    chk("alu_op", alu_op, a[4:2]);
    chk("alu_src", alu_src, a[1:0]);
    chk("ir", ir, m_ir);
    chk("fault", fault, p == 7);
    chk("retired", retired, m_retired);
  endtask

  task automatic drive(input bit rst, input bit rdy,
                       input logic [31:0] rd, input bit z);
    @(negedge clk);
    reset     = rst;
    mem_ready = rst ? 1'b0 : rdy;
    mem_rdata = rd;
    zero      = z;
    if (rst) m_reset();
    #1;
    model_check();
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    drive(1'b1, 1'b0, 32'h0, 1'b0);
  endtask

  function automatic logic [31:0] gen_instr();
    logic [31:0] r;
    logic [5:0] fl [8];
    logic [5:0] ops [8];
    int k, j;
    fl  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h00, 6'h02};
    ops = '{6'h08, 6'h0C, 6'h0D, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02};
    r = $urandom();
    k = $urandom_range(0, 99);
    if (k < 2) return {6'h00, r[25:6], 6'h01};
    if (k < 5) return {6'h3F, r[25:0]};
    j = $urandom_range(0, 8);
    if (j == 0) return {6'h00, r[25:6], fl[$urandom_range(0, 7)]};
    return {ops[j-1], r[25:0]};
  endfunction

  localparam logic [31:0] ADDI = 32'h2010FEFE;
  localparam logic [31:0] LW   = 32'h8D090004;
  localparam logic [31:0] SW   = 32'hAD090008;
  localparam logic [31:0] BEQ  = 32'h11090003;
  localparam logic [31:0] BAD  = 32'hFC000000;

  int  nmem;
  int  stall;
  bit  r_rst, r_rdy;

  initial begin
    m_reset();
    do_reset();
    chk("rst_state", state, 0);
    chk("rst_req", mem_req, 1);
    chk("rst_ir", ir, 0);
    chk("rst_ret", retired, 0);

    // addi through ALU route
    drive(0, 1, ADDI, 0);
    chk("t1_s0", state, 0);
    chk("t1_pcw", pc_write, 1);
    chk("t1_rw0", reg_write, 0);
    drive(0, 0, 0, 0);
    chk("t1_s1", state, 1);
    chk("t1_ir", ir, ADDI);
    drive(0, 0, 0, 0);
    chk("t1_s2", state, 2);
    chk("t1_src", alu_src, 1);
    chk("t1_rw2", reg_write, 0);
    drive(0, 0, 0, 0);
    chk("t1_s4", state, 4);
    chk("t1_rw4", reg_write, 1);
    chk("t1_dst", reg_dst, 0);
    drive(0, 0, 0, 0);
    chk("t1_s5", state, 0);
    chk("t1_ret", retired, 1);

    // lw with memory stalled 3 cycles
    do_reset();
    drive(0, 1, LW, 0);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    chk("t2_exec", state, 2);
    nmem = 0;
    for (int i = 0; i < 4; i++) begin
      drive(0, i == 3, 0, 0);
      if (state == 3) nmem++;
      chk("t2_we", mem_we, 0);
    end
    chk("t2_memcycles", nmem, 4);
    drive(0, 0, 0, 0);
    chk("t2_wb", state, 4);
    chk("t2_m2r", mem_to_reg, 1);
    drive(0, 0, 0, 0);
    chk("t2_end", state, 0);
    chk("t2_ret", retired, 1);

    // beq taken and not taken
    do_reset();
    for (int t = 0; t < 2; t++) begin
      drive(0, 1, BEQ, 0);
      drive(0, 0, 0, 0);
      drive(0, 0, 0, t == 0);
      chk("t3_exec", state, 2);
      chk("t3_pcw", pc_write, t == 0);
      chk("t3_src", pc_src, 1);
      drive(0, 0, 0, 0);
      chk("t3_back", state, 0);
      chk("t3_ret", retired, t + 1);
    end

    // sw memory timeout
    do_reset();
    drive(0, 1, SW, 0);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    for (int i = 0; i < TO; i++) begin
      drive(0, 0, 0, 0);
      chk("t4_mem", state, 3);
    end
    drive(0, 0, 0, 0);
    chk("t4_st", state, 7);
    chk("t4_fault", fault, 1);
    chk("t4_req", mem_req, 0);
    for (int i = 0; i < 20; i++) begin
      drive(0, 1'($urandom_range(0, 1)), 32'h0, 1'b0);
      chk("t4_hold", state, 7);
    end

    // illegal opcode after one retire, then reset
    do_reset();
    drive(0, 1, ADDI, 0);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    drive(0, 1, BAD, 0);
    drive(0, 0, 0, 0);
    chk("t5_dec", state, 1);
    drive(0, 0, 0, 0);
    chk("t5_st", state, 7);
    chk("t5_fault", fault, 1);
    chk("t5_ret1", retired, 1);
    do_reset();
    chk("t5_rst", state, 0);
    chk("t5_f0", fault, 0);
    chk("t5_r0", retired, 0);

    // asynchronous reset in the middle of a sw access
    do_reset();
    drive(0, 1, SW, 0);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    chk("t6_we1", mem_we, 1);
    chk("t6_as1", addr_sel, 1);
    #1;
    reset = 1'b1;
    m_reset();
    #1;
    chk("t6_we0", mem_we, 0);
    chk("t6_as0", addr_sel, 0);
    chk("t6_st", state, 0);
    chk("t6_ret", retired, 0);
    do_reset();

    // randomized traffic
    stall = 0;
    for (int n = 0; n < 4000; n++) begin
      r_rst = 1'b0;
      if (m_fault && $urandom_range(0, 3) == 0) r_rst = 1'b1;
      if ($urandom_range(0, 599) == 0) r_rst = 1'b1;
      if (stall > 0) begin
        r_rdy = 1'b0;
        stall--;
      end else if ($urandom_range(0, 299) == 0) begin
        stall = $urandom_range(8, 20);
        r_rdy = 1'b0;
      end else begin
        r_rdy = ($urandom_range(0, 3) != 0);
      end
      drive(r_rst, r_rdy, gen_instr(), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
